// File: rtl/combo_programmer.sv
// combo_programmer
//   Lets the user enter a new four-digit lock combination (digits 0/1/2 from
//   buttons b0/b1/b2) while the lock is unlocked, asks for it a second time
//   as confirmation, and only then commits it to the code register.
//
// Ports
//   clk         system clock (rising edge), shared with button pulsers and lock
//   rst         synchronous active-high reset
//   prog_en     level, high while the lock is unlocked; programming allowed only then
//   prog_start  one-cycle pulse requesting entry of a new combination
//   b0, b1, b2  one-cycle button pulses, digit value 0, 1, 2
//   code        stored combination (digit 1 in [7:6]), registered
//   code_wr     one-cycle strobe in the cycle a new value first appears on code
//   state       4-bit FSM state for the seven-segment display
//   err         high while in ERR
//   busy        high whenever state is not IDLE
module combo_programmer #(
    parameter int unsigned TIMEOUT      = 8,
    parameter logic [7:0]  DEFAULT_CODE = 8'b00_01_10_00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_en,
    input  logic       prog_start,
    input  logic       b0,
    input  logic       b1,
    input  logic       b2,
    output logic [7:0] code,
    output logic       code_wr,
    output logic [3:0] state,
    output logic       err,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_E1   = 4'd1,
        S_E2   = 4'd2,
        S_E3   = 4'd3,
        S_E4   = 4'd4,
        S_C1   = 4'd5,
        S_C2   = 4'd6,
        S_C3   = 4'd7,
        S_C4   = 4'd8,
        S_DONE = 4'd9,
        S_ERR  = 4'd10
    } state_t;

    // The counter only needs to hold 0..TIMEOUT-1: the last value triggers the exit.
    localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       code_q, code_d;
    logic             code_wr_q, code_wr_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [1:0] npress;
    logic       valid_press;
    logic       multi_press;
    logic [1:0] press_digit;
    logic [1:0] slot;
    logic       timed_out;

    function automatic logic [7:0] put_digit(input logic [7:0] s, input logic [1:0] idx,
                                             input logic [1:0] d);
        logic [7:0] r;
        r = s;
        case (idx)
            2'd0:    r[7:6] = d;
            2'd1:    r[5:4] = d;
            2'd2:    r[3:2] = d;
            default: r[1:0] = d;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] get_digit(input logic [7:0] s, input logic [1:0] idx);
        logic [1:0] r;
        case (idx)
            2'd0:    r = s[7:6];
            2'd1:    r = s[5:4];
            2'd2:    r = s[3:2];
            default: r = s[1:0];
        endcase
        return r;
    endfunction

    assign npress      = 2'(b0) + 2'(b1) + 2'(b2);
    assign valid_press = (npress == 2'd1);
    assign multi_press = npress[1];
    assign press_digit = b2 ? 2'd2 : (b1 ? 2'd1 : 2'd0);
    // E1..E4 (1..4) and C1..C4 (5..8) both map to digit slot 0..3 via the low
    // two state bits minus one.
    assign slot        = 2'(state_q[1:0] - 2'd1);
    assign timed_out   = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (prog_start && prog_en) state_d = S_E1;
            end
            S_E1, S_E2, S_E3, S_E4: begin
                if (multi_press) begin
                    state_d = S_ERR;
                end else if (valid_press) begin
                    shadow_d = put_digit(shadow_q, slot, press_digit);
                    // E4 + 1 is C1, so a plain increment covers the hand-over.
                    state_d  = state_t'(state_q + 4'd1);
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_C1, S_C2, S_C3, S_C4: begin
                if (multi_press) begin
                    state_d = S_ERR;
                end else if (valid_press) begin
                    if (press_digit == get_digit(shadow_q, slot))
                        state_d = state_t'(state_q + 4'd1);  // C4 + 1 is DONE
                    else
                        state_d = S_ERR;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_ERR: begin
                // Presses are deliberately ignored here; only time gets us out.
                if (timed_out) state_d = S_IDLE;
                else           cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Losing unlock aborts whatever is in flight, including ERR and DONE.
        if (state_q != S_IDLE && !prog_en) state_d = S_IDLE;

        // Every accepted press changes state, so a state change covers both
        // "state entry" and "press" as counter-clear events.
        if (state_d != state_q) cnt_d = '0;

        // DONE is only ever reached from C4, so state_d == DONE means entry.
        code_wr_d = (state_d == S_DONE);
        code_d    = code_wr_d ? shadow_q : code_q;
        err_d     = (state_d == S_ERR);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shadow_q  <= '0;
            cnt_q     <= '0;
            code_q    <= DEFAULT_CODE;
            code_wr_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            code_wr_q <= code_wr_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign code    = code_q;
    assign code_wr = code_wr_q;
    assign state   = state_q;
    assign err     = err_q;
    assign busy    = busy_q;

endmodule

// File: doc/combo_programmer.md
COMBO_PROGRAMMER -- requirements
Module: combo_programmer

Interface
REQ-001 The module SHALL have one clock and one synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Parameter TIMEOUT, default 8: number of idle clk cycles allowed between button pulses before an entry aborts.
REQ-003 Parameter DEFAULT_CODE, default 8'b00_01_10_00: combination loaded at reset, four 2-bit digits, digit 1 in [7:6].
REQ-004 clk  input  1  system clock, the same slow clock that drives the button pulse generators and the lock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 prog_en  input  1  level; high while the lock reports unlocked; programming is permitted only while high.
REQ-007 prog_start  input  1  one-cycle pulse that requests entry of a new combination.
REQ-008 b0, b1, b2  input  1 each  one-cycle button pulses from the level-to-pulse stages; digit value is 0, 1 or 2 respectively.
REQ-009 code  output  8  stored combination supplied to the lock's compare logic; registered.
REQ-010 code_wr  output  1  one-cycle strobe, high in the cycle a new code value first appears on code.
REQ-011 state  output  4  FSM state encoding, sized for the existing 4-bit seven-segment decoder.
REQ-012 err  output  1  high while in state ERR.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 State encoding: IDLE=0, E1..E4=1..4 (awaiting new digit n), C1..C4=5..8 (awaiting confirm digit n), DONE=9, ERR=10; codes 11-15 are unused and SHALL return to IDLE on the next cycle.
REQ-015 In IDLE, prog_start high with prog_en high SHALL move the FSM to E1 on the next cycle; prog_start with prog_en low SHALL be ignored.
REQ-016 A "valid press" is a cycle in which exactly one of b0, b1, b2 is high; a "multi press" is a cycle in which two or more are high.
REQ-017 In En, a valid press SHALL store that digit into new-digit slot n in a shadow register; E1-E3 then advance to E(n+1), and E4 advances to C1.
REQ-018 In Cn, a valid press equal to shadow digit n SHALL advance the FSM (C1-C3 to C(n+1), C4 to DONE); a mismatch SHALL go to ERR.
REQ-019 A multi press in any E or C state SHALL go to ERR.
REQ-020 The idle counter SHALL clear on state entry and on every press; if it reaches TIMEOUT in any E or C state, the FSM SHALL go to ERR.
REQ-021 On entry to DONE, code SHALL load the shadow register and code_wr SHALL be 1; DONE SHALL return to IDLE after exactly one cycle.
REQ-022 Latency: the matching C4 press in cycle t SHALL give state=DONE, code=new value and code_wr=1 in cycle t+1, and state=IDLE with code_wr=0 in cycle t+2.
REQ-023 ERR SHALL hold for TIMEOUT cycles and then go to IDLE; button presses in ERR SHALL be ignored; code SHALL remain unchanged.
REQ-024 prog_en going low in any state other than IDLE SHALL force IDLE on the next cycle, with no write and err=0; this applies in DONE after the write has already taken effect.
REQ-025 Button pulses in IDLE SHALL have no effect, and prog_start outside IDLE SHALL be ignored.
REQ-026 code SHALL change only on entry to DONE or on reset; the shadow register SHALL never drive code directly.

Reset
REQ-027 rst SHALL take priority over all other inputs, including mid-entry and during DONE.
REQ-028 Reset values: state=IDLE(0), code=DEFAULT_CODE, shadow=0, idle counter=0, code_wr=0, err=0, busy=0.
REQ-029 A reset asserted in the same cycle as the C4 match SHALL leave code=DEFAULT_CODE with no code_wr.

Verification
REQ-030 The bench SHALL cover happy path: prog_en=1, prog_start, presses b2,b1,b0,b2 then b2,b1,b0,b2 -> code=8'b10_01_00_10, code_wr high for exactly one cycle, state sequence 0,1..8,9,0.
REQ-031 The bench SHALL cover confirm mismatch: entry b0,b0,b0,b0, confirm b0,b1 -> state=10 and err=1 the cycle after the b1 press; code stays 8'b00_01_10_00; after 8 cycles state=0.
REQ-032 The bench SHALL cover multi press: in E2, b0 and b1 in the same cycle -> ERR; no write.
REQ-033 The bench SHALL cover timeout: in E3 with no press for 8 cycles -> ERR; a press in cycle 7 restarts the count, and no ERR occurs.
REQ-034 The bench SHALL cover abort: prog_en dropped in C2 -> state=0 on the next cycle, err=0, code unchanged; prog_start with prog_en=0 -> stays 0.
REQ-035 The bench SHALL cover reset mid-operation: rst in C4 in the same cycle as the matching press -> state=0, code=DEFAULT_CODE, code_wr=0.
